// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, default
// latencies and the sequencer state encoding.
package mdu_seq_pkg;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF   = 4;

  localparam logic [4:0] MDU_NONE  = 5'd0;
  localparam logic [4:0] MDU_MULT  = 5'd1;
  localparam logic [4:0] MDU_MULTU = 5'd2;
  localparam logic [4:0] MDU_DIV   = 5'd3;
  localparam logic [4:0] MDU_DIVU  = 5'd4;
  localparam logic [4:0] MDU_MFHI  = 5'd5;
  localparam logic [4:0] MDU_MFLO  = 5'd6;
  localparam logic [4:0] MDU_MTHI  = 5'd7;
  localparam logic [4:0] MDU_MTLO  = 5'd8;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2
  } mds_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: produces the staged {hi,lo} for mult/multu/div/divu
// and flags a divide by zero so the sequencer can skip the commit.
module mdu_arith
  import mdu_seq_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        signed_div;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    prod_u     = {32'd0, a} * {32'd0, b};
    // The low 64 bits of the product of sign-extended operands is the signed product.
    prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    signed_div = (op == MDU_DIV);
    mag_a      = (signed_div && a[31]) ? (32'd0 - a) : a;
    mag_b      = (signed_div && b[31]) ? (32'd0 - b) : b;
    div0       = is_div_op(op) && (b == 32'd0);
    // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_u        = mag_a / div_b;
    r_u        = mag_a % div_b;
    neg_q      = signed_div && (a[31] ^ b[31]);
    neg_r      = signed_div && a[31];
    res        = 64'd0;
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV,
      MDU_DIVU:  res = {(neg_r ? (32'd0 - r_u) : r_u), (neg_q ? (32'd0 - q_u) : q_u)};
      default:   res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, holds busy for a fixed
// latency per operation and raises the D-stage stall for MDU instructions.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  mdu_op,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_res,
  output logic [1:0]  dbg_state
);

  mds_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      stage_q, stage_d;
  logic             div0_q, div0_d;

  logic [63:0] arith_res;
  logic        arith_div0;
  logic        accept;
  logic        idle_wr;

  mdu_arith u_arith (
    .op   (mdu_op),
    .a    (rs_val),
    .b    (rt_val),
    .res  (arith_res),
    .div0 (arith_div0)
  );

  assign idle_wr = ~flush && (state_q == MDS_IDLE);
  assign accept  = start && idle_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stage_d = stage_q;
    div0_d  = div0_q;
    case (state_q)
      MDS_IDLE: begin
        if (accept && is_mul_op(mdu_op)) begin
          state_d = MDS_MUL;
          cnt_d   = CNT_W'(MUL_LAT - 1);
          stage_d = arith_res;
          div0_d  = 1'b0;
        end else if (accept && is_div_op(mdu_op)) begin
          state_d = MDS_DIV;
          cnt_d   = CNT_W'(DIV_LAT - 1);
          stage_d = arith_res;
          div0_d  = arith_div0;
        end else begin
          if (idle_wr && (mdu_op == MDU_MTHI)) hi_d = rs_val;
          if (idle_wr && (mdu_op == MDU_MTLO)) lo_d = rs_val;
        end
      end
      MDS_MUL, MDS_DIV: begin
        if (cnt_q == '0) begin
          state_d = MDS_IDLE;
          // A divide by zero runs the full latency but leaves HI/LO untouched.
          if (!div0_q) begin
            hi_d = stage_q[63:32];
            lo_d = stage_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MDS_IDLE;
    endcase
    busy_d = (state_d != MDS_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      stage_q <= 64'd0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stage_q <= stage_d;
      div0_q  <= div0_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;
  assign md_stall  = d_uses_md && (busy_q || accept);
  assign mdu_res   = (mdu_op == MDU_MFHI) ? hi_q :
                     (mdu_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table of mult/div operations,
// a few random unsigned ops, and hand sequences for flush, divide by zero and reset.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  // Handshake: an operation is issued when start=1 is presented in an idle
  // cycle without flush; the result is valid once busy falls.

  logic        clk;
  logic        reset;
  logic [4:0]  mdu_op;
  logic        start;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_res;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  mdu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .mdu_op    (mdu_op),
    .start     (start),
    .flush     (flush),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo),
    .mdu_res   (mdu_res),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mdu_op    = MDU_NONE;
    start     = 1'b0;
    flush     = 1'b0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    d_uses_md = 1'b0;
  endtask

  // Issues one operation with d_uses_md held, counts busy cycles, then pops
  // the scoreboard and compares committed HI/LO plus the mfhi/mflo read path.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    logic [63:0] e;
    @(negedge clk);
    mdu_op = op; start = 1'b1; rs_val = a; rt_val = b; d_uses_md = 1'b1;
    #1;
    check({name, "_busy_at_issue"}, {63'd0, busy}, 64'd0);
    check({name, "_stall_at_issue"}, {63'd0, md_stall}, 64'd1);
    exp_q.push_back(exp);
    @(negedge clk);
    mdu_op = MDU_NONE; start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (!md_stall) check({name, "_stall_in_busy"}, {63'd0, md_stall}, 64'd1);
      n++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, 64'(n), 64'(lat));
    check({name, "_stall_release"}, {63'd0, md_stall}, 64'd0);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_hilo"}, {hi, lo}, e);
      mdu_op = MDU_MFHI;
      #1;
      check({name, "_mfhi"}, {32'd0, mdu_res}, {32'd0, e[63:32]});
      mdu_op = MDU_MFLO;
      #1;
      check({name, "_mflo"}, {32'd0, mdu_res}, {32'd0, e[31:0]});
    end
    idle_inputs();
  endtask

  task automatic move_to(input logic [4:0] op, input logic [31:0] v, input logic fl);
    @(negedge clk);
    mdu_op = op; rs_val = v; flush = fl;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{MDU_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[8] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};

    // Reset block
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, 64'd0);
    check("reset_res", {32'd0, mdu_res}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].hi, vecs[i].lo}, vecs[i].lat);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 65535));
      if (i % 2 == 0)
        run_op($sformatf("rnd_multu%0d", i), MDU_MULTU, ra, rb, {32'd0, ra} * {32'd0, rb}, 5);
      else
        run_op($sformatf("rnd_divu%0d", i), MDU_DIVU, ra, rb, {ra % rb, ra / rb}, 10);
    end

    // mthi/mtlo then divide by zero leaves HI/LO alone
    move_to(MDU_MTHI, 32'h12345678, 1'b0);
    check("mthi", {32'd0, hi}, {32'd0, 32'h12345678});
    move_to(MDU_MTLO, 32'hCAFEBABE, 1'b0);
    check("mtlo", {32'd0, lo}, {32'd0, 32'hCAFEBABE});
    run_op("div0", MDU_DIV, 32'd5, 32'd0, {32'h12345678, 32'hCAFEBABE}, 10);

    // Flushed start and flushed mtlo have no effect
    @(negedge clk);
    mdu_op = MDU_MULT; start = 1'b1; flush = 1'b1; rs_val = 32'd9; rt_val = 32'd9;
    d_uses_md = 1'b1;
    #1;
    check("flush_stall", {63'd0, md_stall}, 64'd0);
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hilo", {hi, lo}, {32'h12345678, 32'hCAFEBABE});
    idle_inputs();
    move_to(MDU_MTLO, 32'h0BADF00D, 1'b1);
    check("flush_mtlo", {32'd0, lo}, {32'd0, 32'hCAFEBABE});
    move_to(MDU_MTHI, 32'h0BADF00D, 1'b1);
    check("flush_mthi", {32'd0, hi}, {32'd0, 32'h12345678});

    // mthi while busy is ignored
    @(negedge clk);
    mdu_op = MDU_MULTU; start = 1'b1; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_MTHI; rs_val = 32'hDEADBEEF;
    @(negedge clk);
    idle_inputs();
    repeat (6) @(negedge clk);
    check("mthi_while_busy", {hi, lo}, {32'd0, 32'd6});

    // Asynchronous reset during the third busy cycle of a divide
    @(negedge clk);
    mdu_op = MDU_DIV; start = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post_reset_mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the P7 pipeline.
- Sits beside the ALU in the E stage and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E-stage decode and holds busy for a fixed latency.
- Drives mfhi/mflo read data and the D-stage stall request for instructions that use the MDU.

Parameters:
- MUL_LAT, 5: busy cycles for mult/multu.
- DIV_LAT, 10: busy cycles for div/divu.
- CNT_W, 4: counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mdu_op  in  5  E-stage MDU opcode (MDU_mult, MDU_multu, MDU_div, MDU_divu, MDU_mfhi, MDU_mflo, MDU_mthi, MDU_mtlo, 0 = none).
- start  in  1  E-stage mult/multu/div/divu present.
- flush  in  1  exception/eret flush of the E-stage instruction this cycle.
- rs_val  in  32  forwarded GPR[rs] (operand A, or mthi/mtlo data).
- rt_val  in  32  forwarded GPR[rt] (operand B).
- d_uses_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress (registered).
- md_stall  out  1  stall request to the hazard unit.
- hi  out  32  committed HI.
- lo  out  32  committed LO.
- mdu_res  out  32  mfhi ? hi : mflo ? lo : 0 (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, busy=0.
  - hi=lo=0; staging registers cleared.
  - Applies immediately, including mid-operation; the in-flight result is discarded.
- Acceptance: `accept = start & ~flush & state==IDLE`.
  - start while busy is ignored and is a protocol violation; it cannot occur because of md_stall.
- States:
  - IDLE → MUL on accept of mult/multu; cnt=MUL_LAT-1.
  - IDLE → DIV on accept of div/divu; cnt=DIV_LAT-1.
  - MUL/DIV: cnt decrements each cycle. At cnt==0 on the next edge, commit staged hi/lo and return to IDLE.
- Operation is issued in cycle T. busy=1 in cycles T+1..T+LAT. The new HI/LO are visible from cycle T+LAT+1, the same cycle busy falls.
- Staging: on accept, compute and latch the result from rs_val/rt_val.
  - mult: signed 64-bit product; {hi,lo} = product.
  - multu: unsigned 64-bit product; {hi,lo} = product.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned; lo = quotient, hi = remainder.
  - rt_val==0 for div/divu: busy sequence runs normally, but hi/lo are left unchanged at commit.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- mthi/mtlo: when op matches, ~flush and IDLE, hi (resp. lo) ← rs_val at the edge, with no busy. Ignored while busy.
- Stall: `md_stall = d_uses_md & (busy | accept)`.
  - The D instruction stalls in the issue cycle and throughout busy.
  - It releases in the cycle busy falls, so the following mfhi sees the committed value.
- flush gates only the same-cycle accept and mthi/mtlo. An operation already running is never cancelled by flush.
- mdu_res always reflects committed hi/lo and is never forwarded from staging.

Decomposition:
- Shared header (existing header.v) holds:
  - MDU_* opcode defines.
  - MUL_LAT/DIV_LAT defaults.
  - State encodings `MDS_IDLE`, `MDS_MUL`, `MDS_DIV`.
- One natural sub-module: `mdu_arith`, combinational, computing the 64-bit staged {hi,lo} from op, rs_val and rt_val, plus a div0 flag.
- `mdu_seq` keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- mult rs=0xFFFFFFFE, rt=3 at T → busy=1 for exactly T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA; d_uses_md held → md_stall=1 in T..T+5, 0 at T+6.
- multu rs=0xFFFFFFFE, rt=3 → hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 → lo=3, hi=1; each busy for 10 cycles.
- mthi 0x12345678, mtlo 0xCAFEBABE, then div rt=0 → busy for 10 cycles, then hi=0x12345678, lo=0xCAFEBABE unchanged; mfhi gives mdu_res=0x12345678.
- start=1 with flush=1 → busy stays 0, md_stall=0, hi/lo unchanged; mtlo with flush=1 → lo unchanged.
- reset pulled low during the 3rd busy cycle of div → busy, hi, lo go to 0 without waiting for clk; after release, a new mult issues normally.
